// File: rtl/pc_branch_ctrl_if.sv
// pc_branch_ctrl_if: instruction/flag inputs and PC select/status outputs of pc_branch_ctrl.
interface pc_branch_ctrl_if #(parameter int CNT_W = 32);
    logic [31:0]      instr;
    logic             instr_valid;
    logic             stall_req;
    logic             reg_zero;
    logic             set_flags;
    logic [3:0]       flags_in;
    logic             uncond_br;
    logic             br_taken;
    logic             pc_rd;
    logic             pc_en;
    logic             link_we;
    logic             halted;
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] taken_count;
    modport master (
        output instr, instr_valid, stall_req, reg_zero, set_flags, flags_in,
        input  uncond_br, br_taken, pc_rd, pc_en, link_we, halted, flags_q, br_count, taken_count
    );
    modport slave (
        input  instr, instr_valid, stall_req, reg_zero, set_flags, flags_in,
        output uncond_br, br_taken, pc_rd, pc_en, link_we, halted, flags_q, br_count, taken_count
    );
endinterface

// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl: PC select/enable controller with branch decode, NZCV register,
// RUN/STALL/HALT sequencing and branch performance counters.
module pc_branch_ctrl #(parameter int CNT_W = 32) (
    input  logic            clk,
    input  logic            reset,
    pc_branch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, STALL, HALT} state_t;
    state_t           state_q, state_d;
    logic [3:0]       flags_q, flags_d, eff;
    logic [CNT_W-1:0] br_count_q, br_count_d, taken_count_q, taken_count_d;
    logic             is_b, is_bl, is_cbz, is_cbnz, is_bcond, is_br, is_hlt, is_branch;
    logic             retire, cond_true, br_taken, pc_rd;
    logic [15:0]      cond_vec;
    logic             unused_bits;
    assign unused_bits = ^bus.instr[20:4];
    always_comb begin
        is_b      = bus.instr[31:26] == 6'b000101;
        is_bl     = bus.instr[31:26] == 6'b100101;
        is_cbz    = bus.instr[31:24] == 8'b10110100;
        is_cbnz   = bus.instr[31:24] == 8'b10110101;
        is_bcond  = bus.instr[31:24] == 8'b01010100;
        is_br     = bus.instr[31:21] == 11'b11010110000;
        is_hlt    = bus.instr[31:21] == 11'b11010100010;
        is_branch = is_b | is_bl | is_cbz | is_cbnz | is_bcond | is_br;
        // Forward the current instruction's flags when it sets them.
        eff       = bus.set_flags ? bus.flags_in : flags_q;
        cond_vec  = {2'b11, eff[2] | (eff[3] != eff[0]), !eff[2] & (eff[3] == eff[0]),
                     eff[3] != eff[0], eff[3] == eff[0], !eff[1] | eff[2], eff[1] & !eff[2],
                     !eff[0], eff[0], !eff[3], eff[3], !eff[1], eff[1], !eff[2], eff[2]};
        cond_true = cond_vec[bus.instr[3:0]];
        retire    = state_q != HALT && !bus.stall_req && bus.instr_valid && !is_hlt;
        br_taken  = retire & (is_b | is_bl | (is_cbz & bus.reg_zero) | (is_cbnz & !bus.reg_zero)
                    | (is_bcond & cond_true));
        pc_rd     = retire & is_br;
        state_d   = state_q == HALT ? HALT : bus.stall_req ? STALL
                    : (state_q == RUN && bus.instr_valid && is_hlt) ? HALT : RUN;
        flags_d   = (retire && bus.set_flags) ? bus.flags_in : flags_q;
        br_count_d    = br_count_q + CNT_W'(retire & is_branch);
        taken_count_d = taken_count_q + CNT_W'(br_taken | pc_rd);
        bus.uncond_br   = retire & (is_b | is_bl);
        bus.br_taken    = br_taken;
        bus.pc_rd       = pc_rd;
        bus.link_we     = retire & is_bl;
        bus.pc_en       = retire | (!bus.instr_valid & !bus.stall_req & state_q != HALT);
        bus.halted      = state_q == HALT;
        bus.flags_q     = flags_q;
        bus.br_count    = br_count_q;
        bus.taken_count = taken_count_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            flags_q       <= 4'b0000;
            br_count_q    <= '0;
            taken_count_q <= '0;
        end else begin
            state_q       <= state_d;
            flags_q       <= flags_d;
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
        end
    end
endmodule

// File: doc/pc_branch_ctrl.md
# pc_branch_ctrl

Branch and sequencing controller for the program counter of the single-cycle ARMv8 (LEGv8 subset) core. It decodes the instruction at the current PC, evaluates branch conditions against a registered NZCV flag set (with same-cycle forwarding), and drives the PC's select lines: `uncond_br`, `br_taken`, `pc_rd` and a new register enable `pc_en`. It also freezes the PC on memory stalls, halts on HLT, requests the BL link write, and keeps branch performance counters.

## Interface
Parameters:
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- instr  in  32  instruction at current PC.
- instr_valid  in  1  instr is valid this cycle.
- stall_req  in  1  data memory busy; freeze PC this cycle.
- reg_zero  in  1  register Rt read value == 0 (for CBZ/CBNZ).
- set_flags  in  1  current instruction is flag-setting (ADDS/SUBS/ANDS).
- flags_in  in  4  ALU NZCV result {N,Z,C,V} of current instruction.
- uncond_br  out  1  1 = 26-bit offset select, 0 = 19-bit.
- br_taken  out  1  PC <= PC + offset*4.
- pc_rd  out  1  PC <= register value (BR).
- pc_en  out  1  PC register load enable.
- link_we  out  1  write PC+4 into X30 (BL).
- halted  out  1  controller in HALT.
- flags_q  out  4  architectural NZCV register.
- br_count  out  CNT_W  branch instructions retired.
- taken_count  out  CNT_W  branches taken.

## Operation
- Decode (instr_valid=1): B instr[31:26]=000101; BL 100101; CBZ instr[31:24]=10110100; CBNZ 10110101; B.cond 01010100 with cond=instr[3:0]; BR instr[31:21]=11010110000; HLT instr[31:21]=11010100010. Anything else = non-branch.
- FSM states RUN, STALL, HALT.
  - RUN: stall_req=1 -> STALL; valid HLT and stall_req=0 -> HALT; else RUN.
  - STALL: stall_req=0 -> RUN; else stay.
  - HALT: terminal until reset.
- Outputs are combinational from state and instr; they are active only when `retire` = (state==RUN or STALL) & stall_req=0 & instr_valid=1 & not HLT.
- pc_en = retire or (instr_valid=0 & stall_req=0 & state!=HALT). pc_en=0 in HALT, during any stall_req, and on the HLT cycle itself.
- When retire=1:
  - B: uncond_br=1, br_taken=1.
  - BL: same as B, plus link_we=1.
  - CBZ/CBNZ: uncond_br=0, br_taken=reg_zero (CBZ) or !reg_zero (CBNZ).
  - B.cond: uncond_br=0, br_taken=cond_true.
  - BR: pc_rd=1, br_taken=0.
  - Otherwise all selects are 0.
- cond_true uses the effective flags: flags_in when set_flags=1 this cycle (forwarding), else flags_q. Codes:
  - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14, 15 always.
- flags_q <= flags_in at posedge when set_flags=1 and retire=1. No update during a stall or in HALT.
- Counters update on retire of a branch (B, BL, CBZ, CBNZ, B.cond, BR):
  - br_count +1.
  - taken_count +1 if br_taken or pc_rd.
  - Both wrap modulo 2^CNT_W.

## Timing
- Reset values: state RUN, flags_q 0000, br_count 0, taken_count 0, halted 0. With instr_valid=0 and stall_req=0, pc_en=1 and all selects are 0.
- Zero-cycle latency: selects are valid in the same cycle as instr; the PC captures them at the next posedge.
- A stall_req asserted mid-branch suppresses the selects, link_we and counter updates. The branch retires in the first cycle stall_req=0.
- set_flags with B.cond in the same instruction is impossible. Forwarding covers a flag-setter followed by a branch only when a stall holds both in the same cycle (not required); the common case is the branch reading flags_q.
- reset in any state, including HALT or STALL, overrides everything the next cycle.

## Test plan
- Reset, then 3 non-branch instrs -> pc_en=1, selects 0, br_count=0 after each.
- B offset 328 -> uncond_br=1, br_taken=1, br_count=1, taken_count=1. BL -> same plus link_we=1.
- SUBS with flags_in=0100 (Z=1), next cycle B.EQ -> br_taken=1. B.NE -> br_taken=0, br_count incremented, taken_count unchanged.
- CBZ with reg_zero=0 -> br_taken=0. CBNZ with reg_zero=0 -> br_taken=1, uncond_br=0.
- BL with stall_req=1 for 3 cycles -> pc_en=0, link_we=0, counters frozen, state STALL. On release, one cycle of link_we=1 and counters +1.
- HLT -> next cycle halted=1, pc_en=0, and a following B has no effect. Reset -> halted=0, pc_en=1, flags_q=0000.
